// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_pkg
//  Purpose  : Shared definitions for the branch predictor: 2-bit direction
//             counter encoding, the per-entry BTB flag record and the helper
//             functions that derive index/tag widths from XLEN and ENTRIES.
//  Revision : 1.0  initial release
// ============================================================================
package bp_pkg;

  // 2-bit saturating direction counter; bit 1 is the taken prediction.
  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;  // strong not-taken
  localparam ctr_t WNT = 2'b01;  // weak not-taken (reset value)
  localparam ctr_t WT  = 2'b10;  // weak taken (allocation value)
  localparam ctr_t ST  = 2'b11;  // strong taken

  // Width-independent part of a BTB entry. The tag and target fields depend
  // on module parameters, so the top wraps this record together with them.
  typedef struct packed {
    logic valid;
    logic jump;
    ctr_t ctr;
  } btb_flags_t;

  function automatic int calc_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int calc_tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sat_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : bp_sat_ctr
//  Purpose  : Next-state logic of a 2-bit saturating counter.
//  Ports    : ctr     - current counter value
//             inc     - 1 = count up (taken), 0 = count down (not taken)
//             ctr_nxt - saturated next value (ST stays ST, SNT stays SNT)
//  Revision : 1.0  initial release
// ============================================================================
module bp_sat_ctr
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic inc,
  output ctr_t ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (inc) begin
      if (ctr != ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Direct-mapped BTB with 2-bit direction counters. Looked up by
//             fetch (1-cycle registered result), trained by execute, and keeps
//             saturating mispredict statistics.
//  Config   : BP_GSHARE_EN - when defined, direction counters live in a
//             separate table indexed by pc-index XOR global history;
//             otherwise (default) the counter sits in the BTB entry.
//  Ports    : clk, rst (async, active-high)
//             f_valid/f_pc                      - fetch lookup request
//             p_valid/p_hit/p_taken/p_target    - registered prediction
//             u_valid/u_pc/u_jump/u_taken/u_target/u_pred_taken/
//             u_pred_target                     - resolved instruction update
//             u_mispredict                      - registered mispredict flag
//             clr_stats, cnt_branch, cnt_mispred - statistics
//  Revision : 1.0  initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int GHR_W   = 6,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_valid,
  input  logic [XLEN-1:0]  f_pc,
  output logic             p_valid,
  output logic             p_hit,
  output logic             p_taken,
  output logic [XLEN-1:0]  p_target,
  input  logic             u_valid,
  input  logic [XLEN-1:0]  u_pc,
  input  logic             u_jump,
  input  logic             u_taken,
  input  logic [XLEN-1:0]  u_target,
  input  logic             u_pred_taken,
  input  logic [XLEN-1:0]  u_pred_target,
  output logic             u_mispredict,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispred
);

  localparam int IDX_W = calc_idx_w(ENTRIES);
  localparam int TAG_W = calc_tag_w(XLEN, ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    btb_flags_t       flags;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } btb_entry_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  btb_entry_t       btb_q [ENTRIES];
  logic             p_valid_q, p_valid_d;
  logic             p_hit_q, p_hit_d;
  logic             p_taken_q, p_taken_d;
  logic [XLEN-1:0]  p_target_q, p_target_d;
  logic             u_mispredict_q, u_mispredict_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;

  // --------------------------------------------------------------------------
  // Address split
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             unused_pc_bits;

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[XLEN-1:IDX_W+2];
  assign u_idx = u_pc[IDX_W+1:2];
  assign u_tag = u_pc[XLEN-1:IDX_W+2];
  // Instructions are word-aligned; the low update-PC bits carry no information.
  assign unused_pc_bits = ^u_pc[1:0];

  // --------------------------------------------------------------------------
  // Direction counter source (bimodal in-entry, or gshare side table)
  // --------------------------------------------------------------------------
  btb_entry_t rd_entry;   // entry seen by the lookup
  btb_entry_t u_entry;    // entry seen by the update
  ctr_t       f_ctr;
  ctr_t       u_ctr;
  ctr_t       u_ctr_nxt;

  assign rd_entry = btb_q[f_idx];
  assign u_entry  = btb_q[u_idx];

`ifdef BP_GSHARE_EN
  ctr_t             pht_q [ENTRIES];
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] f_pidx, u_pidx;

  // Zero-extend without a replication that could become zero-width.
  always_comb begin
    ghr_ext              = '0;
    ghr_ext[GHR_W-1:0]   = ghr_q;
  end

  assign f_pidx = f_idx ^ ghr_ext;
  assign u_pidx = u_idx ^ ghr_ext;
  assign f_ctr  = pht_q[f_pidx];
  assign u_ctr  = pht_q[u_pidx];
`else
  assign f_ctr  = rd_entry.flags.ctr;
  assign u_ctr  = u_entry.flags.ctr;
`endif

  bp_sat_ctr u_sat_ctr (
    .ctr     (u_ctr),
    .inc     (u_taken),
    .ctr_nxt (u_ctr_nxt)
  );

  // --------------------------------------------------------------------------
  // Lookup: registered, holds the last result while f_valid is low.
  // Reads the table before any same-edge write, giving read-before-write.
  // --------------------------------------------------------------------------
  logic f_hit, f_taken;

  assign f_hit   = rd_entry.flags.valid && (rd_entry.tag == f_tag);
  assign f_taken = f_hit && (rd_entry.flags.jump || f_ctr[1]);

  always_comb begin
    p_valid_d  = f_valid;
    p_hit_d    = p_hit_q;
    p_taken_d  = p_taken_q;
    p_target_d = p_target_q;
    if (f_valid) begin
      p_hit_d    = f_hit;
      p_taken_d  = f_taken;
      p_target_d = f_taken ? rd_entry.target : f_pc + XLEN'(4);
    end
  end

  // --------------------------------------------------------------------------
  // Update: a hit retrains, a taken miss allocates, a not-taken miss is dropped.
  // --------------------------------------------------------------------------
  logic       u_hit;
  logic       btb_wr_en;
  btb_entry_t btb_wr_d;
  logic       ctr_wr_en;   // direction counter write (gshare table)
  ctr_t       ctr_wr_d;

  assign u_hit = u_entry.flags.valid && (u_entry.tag == u_tag);

  always_comb begin
    btb_wr_en = 1'b0;
    btb_wr_d  = u_entry;
    ctr_wr_en = 1'b0;
    ctr_wr_d  = u_ctr;
    if (u_valid) begin
      if (u_hit) begin
        btb_wr_en = 1'b1;
        // Only conditional branches train the direction counter.
        if (!u_jump) begin
          ctr_wr_en = 1'b1;
          ctr_wr_d  = u_ctr_nxt;
`ifndef BP_GSHARE_EN
          btb_wr_d.flags.ctr = u_ctr_nxt;
`endif
        end
        if (u_taken) btb_wr_d.target = u_target;
      end else if (u_taken) begin
        btb_wr_en            = 1'b1;
        btb_wr_d.flags.valid = 1'b1;
        btb_wr_d.flags.jump  = u_jump;
        btb_wr_d.flags.ctr   = WT;
        btb_wr_d.tag         = u_tag;
        btb_wr_d.target      = u_target;
        ctr_wr_en            = 1'b1;
        ctr_wr_d             = WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].flags.valid <= 1'b0;
        btb_q[i].flags.jump  <= 1'b0;
        btb_q[i].flags.ctr   <= WNT;
        btb_q[i].tag         <= '0;
        btb_q[i].target      <= '0;
      end
    end else if (btb_wr_en) begin
      btb_q[u_idx] <= btb_wr_d;
    end
  end

`ifdef BP_GSHARE_EN
  // History shifts in each conditional outcome; JAL does not disturb it.
  always_comb begin
    ghr_d = ghr_q;
    if (u_valid && !u_jump) ghr_d = (ghr_q << 1) | GHR_W'(u_taken);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= WNT;
    end else begin
      ghr_q <= ghr_d;
      if (ctr_wr_en) pht_q[u_pidx] <= ctr_wr_d;
    end
  end
`else
  logic unused_ctr_wr;
  assign unused_ctr_wr = ctr_wr_en ^ (^ctr_wr_d);
`endif

  // --------------------------------------------------------------------------
  // Mispredict flag and saturating statistics (clear beats increment)
  // --------------------------------------------------------------------------
  always_comb begin
    u_mispredict_d = u_valid &&
                     ((u_pred_taken != u_taken) ||
                      (u_taken && (u_pred_target != u_target)));
    cnt_branch_d  = cnt_branch_q;
    cnt_mispred_d = cnt_mispred_q;
    if (clr_stats) begin
      cnt_branch_d  = '0;
      cnt_mispred_d = '0;
    end else begin
      if (u_valid && (cnt_branch_q != CNT_MAX))
        cnt_branch_d = cnt_branch_q + CNT_W'(1);
      if (u_mispredict_d && (cnt_mispred_q != CNT_MAX))
        cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q      <= 1'b0;
      p_hit_q        <= 1'b0;
      p_taken_q      <= 1'b0;
      p_target_q     <= '0;
      u_mispredict_q <= 1'b0;
      cnt_branch_q   <= '0;
      cnt_mispred_q  <= '0;
    end else begin
      p_valid_q      <= p_valid_d;
      p_hit_q        <= p_hit_d;
      p_taken_q      <= p_taken_d;
      p_target_q     <= p_target_d;
      u_mispredict_q <= u_mispredict_d;
      cnt_branch_q   <= cnt_branch_d;
      cnt_mispred_q  <= cnt_mispred_d;
    end
  end

  assign p_valid      = p_valid_q;
  assign p_hit        = p_hit_q;
  assign p_taken      = p_taken_q;
  assign p_target     = p_target_q;
  assign u_mispredict = u_mispredict_q;
  assign cnt_branch   = cnt_branch_q;
  assign cnt_mispred  = cnt_mispred_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor
//  Purpose  : Directed, table-driven self-checking bench for branch_predictor
//             (default bimodal build, ENTRIES = 64).
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        p_valid, p_hit, p_taken;
  logic [31:0] p_target;
  logic        u_valid, u_jump, u_taken, u_pred_taken;
  logic [31:0] u_pc, u_target, u_pred_target;
  logic        u_mispredict;
  logic        clr_stats;
  logic [31:0] cnt_branch, cnt_mispred;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .GHR_W(6), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .f_valid       (f_valid),
    .f_pc          (f_pc),
    .p_valid       (p_valid),
    .p_hit         (p_hit),
    .p_taken       (p_taken),
    .p_target      (p_target),
    .u_valid       (u_valid),
    .u_pc          (u_pc),
    .u_jump        (u_jump),
    .u_taken       (u_taken),
    .u_target      (u_target),
    .u_pred_taken  (u_pred_taken),
    .u_pred_target (u_pred_target),
    .u_mispredict  (u_mispredict),
    .clr_stats     (clr_stats),
    .cnt_branch    (cnt_branch),
    .cnt_mispred   (cnt_mispred)
  );

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic        uj, ut;
    logic [31:0] utg;
    logic        upt;
    logic [31:0] uptg;
    logic        clr;
    logic        ev, eh, et;
    logic [31:0] etg;
    logic        em;
    int          ecb, ecm;
  } vec_t;

  function automatic vec_t mk(
    input logic fv, input logic [31:0] fpc,
    input logic uv, input logic [31:0] upc, input logic uj, input logic ut,
    input logic [31:0] utg, input logic upt, input logic [31:0] uptg,
    input logic clr,
    input logic ev, input logic eh, input logic et, input logic [31:0] etg,
    input logic em, input int ecb, input int ecm);
    vec_t r;
    r.fv = fv;  r.fpc = fpc;  r.uv = uv;  r.upc = upc;  r.uj = uj;  r.ut = ut;
    r.utg = utg; r.upt = upt; r.uptg = uptg; r.clr = clr;
    r.ev = ev;  r.eh = eh;  r.et = et;  r.etg = etg;  r.em = em;
    r.ecb = ecb; r.ecm = ecm;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    f_valid       = v.fv;
    f_pc          = v.fpc;
    u_valid       = v.uv;
    u_pc          = v.upc;
    u_jump        = v.uj;
    u_taken       = v.ut;
    u_target      = v.utg;
    u_pred_taken  = v.upt;
    u_pred_target = v.uptg;
    clr_stats     = v.clr;
  endtask

  task automatic idle();
    f_valid = 0; f_pc = 0; u_valid = 0; u_pc = 0; u_jump = 0; u_taken = 0;
    u_target = 0; u_pred_taken = 0; u_pred_target = 0; clr_stats = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " p_valid"}, 32'(p_valid), 0);
    chk({tag, " p_hit"}, 32'(p_hit), 0);
    chk({tag, " p_taken"}, 32'(p_taken), 0);
    chk({tag, " p_target"}, p_target, 0);
    chk({tag, " u_mispredict"}, 32'(u_mispredict), 0);
    chk({tag, " cnt_branch"}, cnt_branch, 0);
    chk({tag, " cnt_mispred"}, cnt_mispred, 0);
  endtask

  // One lookup cycle on an otherwise idle bus; expects a miss.
  task automatic lookup_miss(input string tag, input logic [31:0] pc);
    idle();
    f_valid = 1;
    f_pc    = pc;
    @(posedge clk); #1;
    chk({tag, " p_valid"}, 32'(p_valid), 1);
    chk({tag, " p_hit"}, 32'(p_hit), 0);
    chk({tag, " p_taken"}, 32'(p_taken), 0);
    chk({tag, " p_target"}, p_target, pc + 32'd4);
  endtask

  vec_t tbl [22];

  initial begin
    //                fv fpc            uv upc     uj ut utg     upt uptg    clr ev eh et etg      em cb cm
    tbl[0]  = mk(1, 32'h100,       0, 0,       0, 0, 0,       0, 0,       0, 1, 0, 0, 32'h104, 0, 0, 0);
    tbl[1]  = mk(0, 0,             1, 32'h100, 0, 1, 32'h40,  0, 32'h104, 0, 0, 0, 0, 32'h104, 1, 1, 1);
    tbl[2]  = mk(1, 32'h100,       0, 0,       0, 0, 0,       0, 0,       0, 1, 1, 1, 32'h40,  0, 1, 1);
    // Lookup sees ctr=10 although the same edge moves it to 01.
    tbl[3]  = mk(1, 32'h100,       1, 32'h100, 0, 0, 0,       1, 32'h40,  0, 1, 1, 1, 32'h40,  1, 2, 2);
    tbl[4]  = mk(1, 32'h100,       1, 32'h100, 0, 0, 0,       0, 32'h104, 0, 1, 1, 0, 32'h104, 0, 3, 2);
    tbl[5]  = mk(1, 32'h100,       0, 0,       0, 0, 0,       0, 0,       0, 1, 1, 0, 32'h104, 0, 3, 2);
    // JAL at 0x200 shares index 0 with 0x100 and evicts it.
    tbl[6]  = mk(0, 0,             1, 32'h200, 1, 1, 32'h80,  0, 32'h204, 0, 0, 1, 0, 32'h104, 1, 4, 3);
    tbl[7]  = mk(1, 32'h200,       0, 0,       0, 0, 0,       0, 0,       0, 1, 1, 1, 32'h80,  0, 4, 3);
    tbl[8]  = mk(1, 32'h100,       0, 0,       0, 0, 0,       0, 0,       0, 1, 0, 0, 32'h104, 0, 4, 3);
    tbl[9]  = mk(1, 32'h200,       1, 32'h200, 1, 1, 32'h80,  1, 32'h80,  0, 1, 1, 1, 32'h80,  0, 5, 3);
    // Not-taken conditional updates drive the ctr to 00; jump flag keeps it taken.
    tbl[10] = mk(0, 0,             1, 32'h200, 0, 0, 0,       1, 32'h80,  0, 0, 1, 1, 32'h80,  1, 6, 4);
    tbl[11] = mk(0, 0,             1, 32'h200, 0, 0, 0,       1, 32'h80,  0, 0, 1, 1, 32'h80,  1, 7, 5);
    tbl[12] = mk(1, 32'h200,       0, 0,       0, 0, 0,       0, 0,       0, 1, 1, 1, 32'h80,  0, 7, 5);
    // Right direction, wrong target: mispredict, target retrained.
    tbl[13] = mk(0, 0,             1, 32'h200, 1, 1, 32'h90,  1, 32'h80,  0, 0, 1, 1, 32'h80,  1, 8, 6);
    tbl[14] = mk(1, 32'h200,       0, 0,       0, 0, 0,       0, 0,       0, 1, 1, 1, 32'h90,  0, 8, 6);
    // Not-taken miss must not allocate.
    tbl[15] = mk(0, 0,             1, 32'h104, 0, 0, 0,       0, 32'h108, 0, 0, 1, 1, 32'h90,  0, 9, 6);
    tbl[16] = mk(1, 32'h104,       0, 0,       0, 0, 0,       0, 0,       0, 1, 0, 0, 32'h108, 0, 9, 6);
    // Same-cycle lookup and first taken update: lookup misses, next one hits.
    tbl[17] = mk(1, 32'h300,       1, 32'h300, 0, 1, 32'h500, 0, 32'h304, 0, 1, 0, 0, 32'h304, 1, 10, 7);
    tbl[18] = mk(1, 32'h300,       0, 0,       0, 0, 0,       0, 0,       0, 1, 1, 1, 32'h500, 0, 10, 7);
    // Fall-through wraps modulo 2^32.
    tbl[19] = mk(1, 32'hFFFFFFFC,  0, 0,       0, 0, 0,       0, 0,       0, 1, 0, 0, 32'h0,   0, 10, 7);
    // Clear wins over a same-cycle (mispredicted) update.
    tbl[20] = mk(0, 0,             1, 32'h104, 0, 0, 0,       1, 32'h108, 1, 0, 0, 0, 32'h0,   1, 0, 0);
    tbl[21] = mk(0, 0,             0, 0,       0, 0, 0,       0, 0,       0, 0, 0, 0, 32'h0,   0, 0, 0);

    idle();
    rst = 1'b1;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      chk($sformatf("r%0d p_valid", i), 32'(p_valid), 32'(tbl[i].ev));
      chk($sformatf("r%0d p_hit", i), 32'(p_hit), 32'(tbl[i].eh));
      chk($sformatf("r%0d p_taken", i), 32'(p_taken), 32'(tbl[i].et));
      chk($sformatf("r%0d p_target", i), p_target, tbl[i].etg);
      chk($sformatf("r%0d u_mispredict", i), 32'(u_mispredict), 32'(tbl[i].em));
      chk($sformatf("r%0d cnt_branch", i), cnt_branch, 32'(tbl[i].ecb));
      chk($sformatf("r%0d cnt_mispred", i), cnt_mispred, 32'(tbl[i].ecm));
    end

    // Build up live state: 0x300 hits, a mispredicted taken update of 0x400
    // allocates over it.
    idle();
    f_valid = 1; f_pc = 32'h300;
    u_valid = 1; u_pc = 32'h400; u_taken = 1; u_target = 32'h600;
    u_pred_taken = 0; u_pred_target = 32'h404;
    @(posedge clk); #1;
    chk("pre-rst p_hit", 32'(p_hit), 1);
    chk("pre-rst p_target", p_target, 32'h500);
    chk("pre-rst u_mispredict", 32'(u_mispredict), 1);
    chk("pre-rst cnt_branch", cnt_branch, 1);
    chk("pre-rst cnt_mispred", cnt_mispred, 1);

    // Asynchronous reset with an update of 0x404 in flight.
    f_pc = 32'h400;
    u_pc = 32'h404; u_target = 32'h700;
    #3 rst = 1'b1;
    #1;
    chk_all_zero("async-rst");
    @(posedge clk); #1;
    chk_all_zero("rst-held");
    @(negedge clk);
    rst = 1'b0;
    idle();

    lookup_miss("post-rst 0x300", 32'h300);
    lookup_miss("post-rst 0x400", 32'h400);
    lookup_miss("post-rst 0x404", 32'h404);
    lookup_miss("post-rst 0x200", 32'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
